// File: rtl/ctrl_sync_arb.sv
// ctrl_sync_arb
//
// Round-robin scheduler that lets several source-side requesters share one
// ctrl_sync pulse channel. Single-cycle request pulses are latched into a
// pending register. One pulse at a time is issued into the synchronizer,
// with the granted index held on a side bus. The scheduler then waits for
// the acknowledge, which a reverse ctrl_sync has already brought back into
// this clock domain. A stuck channel is bounded by a timeout, and a short
// idle gap is enforced after each transaction.
//
// Ports:
//   clk          - single clock; source domain of the shared ctrl_sync
//   rst_n        - asynchronous, active-low reset
//   req_i        - per-requester single-cycle request pulses
//   sync_ack_i   - single-cycle ack, already synchronized to clk
//   sync_ctrl_o  - single-cycle pulse into ctrl_sync.ctrl_i
//   sync_id_o    - index of the granted requester, held from ISSUE to IDLE
//   done_o       - one-cycle pulse on the granted bit when its ack arrives
//   err_o        - one-cycle pulse on the granted bit when it times out
//   pending_o    - latched requests not yet issued
//   busy_o       - high whenever the scheduler is not idle

module ctrl_sync_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int GAP_CYC = 2,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               sync_ack_i,
   output logic               sync_ctrl_o,
   output logic [ID_W-1:0]    sync_id_o,
   output logic [NUM_REQ-1:0] done_o,
   output logic [NUM_REQ-1:0] err_o,
   output logic [NUM_REQ-1:0] pending_o,
   output logic               busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_GAP
   } state_t;

   // The timer value seen in the last allowed WAIT cycle. The gap counter
   // value seen in the last GAP cycle.
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [NUM_REQ-1:0] sel_mask_q, sel_mask_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic [CNT_W-1:0]   gap_q, gap_d;
   logic               ctrl_q, ctrl_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [NUM_REQ-1:0] err_q, err_d;

   logic               pick_found;
   logic [ID_W-1:0]    pick_id;
   logic [NUM_REQ-1:0] pick_mask;
   logic [ID_W-1:0]    pick_ptr;
   int                 cand;

   // Round-robin search: walk upward from ptr with wrap, and take the first
   // pending requester. The grant is kept as a one-hot mask so that clearing
   // pending and pulsing done/err never needs a variable bit index.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      pick_mask  = '0;
      pick_ptr   = '0;
      cand       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!pick_found && ((pending_q & (NUM_REQ'(1) << cand)) != '0)) begin
            pick_found = 1'b1;
            pick_id    = ID_W'(cand);
            pick_mask  = NUM_REQ'(1) << cand;
            pick_ptr   = (cand == NUM_REQ - 1) ? '0 : ID_W'(cand + 1);
         end
      end
   end

   // Next-state and next-output logic. New request pulses are always OR-ed
   // into pending, after the issued bit is cleared. This way a requester
   // that pulses in its own grant cycle keeps its request alive.
   // done/err/ctrl default to zero, so each of them is a one-cycle pulse.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q | req_i;
      ptr_d      = ptr_q;
      sel_mask_d = sel_mask_q;
      timer_d    = timer_q;
      gap_d      = gap_q;
      ctrl_d     = 1'b0;
      id_d       = id_q;
      done_d     = '0;
      err_d      = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d    = ST_ISSUE;
               ctrl_d     = 1'b1;
               id_d       = pick_id;
               sel_mask_d = pick_mask;
               ptr_d      = pick_ptr;
               pending_d  = (pending_q & ~pick_mask) | req_i;
            end
         end
         ST_ISSUE: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // The ack is checked first, so an ack in the final allowed cycle
            // completes normally instead of reporting a timeout.
            if (sync_ack_i) begin
               done_d  = sel_mask_q;
               gap_d   = '0;
               state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            end else if (timer_q == TIMEOUT_LAST) begin
               err_d   = sel_mask_q;
               gap_d   = '0;
               state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers. Reset drops everything, including any
   // outstanding grant, so no done/err is ever produced for it later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         ptr_q      <= '0;
         sel_mask_q <= '0;
         timer_q    <= '0;
         gap_q      <= '0;
         ctrl_q     <= 1'b0;
         id_q       <= '0;
         done_q     <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         ptr_q      <= ptr_d;
         sel_mask_q <= sel_mask_d;
         timer_q    <= timer_d;
         gap_q      <= gap_d;
         ctrl_q     <= ctrl_d;
         id_q       <= id_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign sync_ctrl_o = ctrl_q;
   assign sync_id_o   = id_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign pending_o   = pending_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ctrl_sync_arb.sv
// tb_ctrl_sync_arb
//
// Directed bench for ctrl_sync_arb (NUM_REQ=4, GAP_CYC=2, TIMEOUT=16).
// A transaction-level model predicts every output on every cycle. Directed
// scenarios also pin specific latencies and orders to hand-computed values.

module tb_ctrl_sync_arb;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int GAP_CYC = 2;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 8;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req_i;
   logic         sync_ack_i;
   logic         sync_ctrl_o;
   logic [1:0]   sync_id_o;
   logic [3:0]   done_o;
   logic [3:0]   err_o;
   logic [3:0]   pending_o;
   logic         busy_o;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   // Model state: the pending set, the round-robin pointer, and the timeline
   // of the one outstanding transaction (issue cycle, finish cycle).
   logic [3:0] m_pend;
   int         m_ptr;
   int         m_sel;
   int         m_id;
   bit         m_active;
   int         m_issue;
   int         m_fin;
   logic       e_ctrl;
   logic [3:0] e_done;
   logic [3:0] e_err;

   int         rr_ids  [3] = '{0, 1, 3};
   logic [3:0] rr_pend [3] = '{4'b1010, 4'b1000, 4'b0000};

   ctrl_sync_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W),
      .GAP_CYC (GAP_CYC),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .sync_ack_i  (sync_ack_i),
      .sync_ctrl_o (sync_ctrl_o),
      .sync_id_o   (sync_id_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .pending_o   (pending_o),
      .busy_o      (busy_o)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so that the run always ends, even if a wait goes wrong.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Drives inputs just after the falling edge. They then hold for the next
   // rising edge, which ends the current cycle.
   task automatic applyStimulus(input logic [3:0] req, input logic ack);
      @(negedge clk);
      req_i      = req;
      sync_ack_i = ack;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n      = 1'b0;
      req_i      = '0;
      sync_ack_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Idles the inputs until an issue pulse is seen (bounded).
   task automatic waitCtrl(output int c, output int id);
      c  = -1;
      id = -1;
      for (int i = 0; i < 40; i++) begin
         if (sync_ctrl_o) begin
            c  = cyc;
            id = int'(sync_id_o);
            break;
         end
         applyStimulus(4'b0000, 1'b0);
      end
      checkOutput("ctrl_seen", (c >= 0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   function automatic void model_reset();
      m_pend   = '0;
      m_ptr    = 0;
      m_sel    = 0;
      m_id     = 0;
      m_active = 1'b0;
      m_issue  = 0;
      m_fin    = -1;
      e_ctrl   = 1'b0;
      e_done   = '0;
      e_err    = '0;
   endfunction

   // Advances the model into cycle n, using the inputs seen during cycle n-1.
   // A transaction issued at cycle i waits during i+1..i+TIMEOUT. It finishes
   // one cycle after the ack (or after the last wait), and the scheduler is
   // free again GAP_CYC cycles after it finishes.
   function automatic void model_step(int n, logic [3:0] req, logic ack);
      bit was_idle;
      was_idle = !m_active;
      e_ctrl   = 1'b0;
      e_done   = '0;
      e_err    = '0;
      if (m_active && m_fin < 0 && (n - 1) > m_issue) begin
         if (ack) begin
            m_fin  = n;
            e_done = 4'(1 << m_sel);
         end else if ((n - 1) - m_issue == TIMEOUT) begin
            m_fin = n;
            e_err = 4'(1 << m_sel);
         end
      end
      if (m_active && m_fin >= 0 && n >= m_fin + GAP_CYC) begin
         m_active = 1'b0;
      end
      if (was_idle && m_pend != 0) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (m_ptr + k) % NUM_REQ;
            if (((m_pend >> j) & 4'b0001) != 0) begin
               m_sel = j;
               break;
            end
         end
         m_id     = m_sel;
         m_issue  = n;
         m_fin    = -1;
         m_active = 1'b1;
         m_ptr    = (m_sel + 1) % NUM_REQ;
         m_pend   = m_pend & ~(4'(1) << m_sel);
         e_ctrl   = 1'b1;
      end
      m_pend = m_pend | req;
   endfunction

   // Compare process: steps the model at every rising edge, then checks all
   // outputs shortly after the edge.
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            model_reset();
         end else begin
            model_step(cyc, req_i, sync_ack_i);
         end
         #1;
         checkOutput("cyc_sync_ctrl", 32'(sync_ctrl_o), 32'(e_ctrl));
         checkOutput("cyc_sync_id",   32'(sync_id_o),   m_id);
         checkOutput("cyc_done",      32'(done_o),      32'(e_done));
         checkOutput("cyc_err",       32'(err_o),       32'(e_err));
         checkOutput("cyc_pending",   32'(pending_o),   32'(m_pend));
         checkOutput("cyc_busy",      32'(busy_o),      32'(m_active));
      end
   end

   // Directed scenarios.
   initial begin
      int t;
      int c;
      int c2;
      int e;
      int id;
      int id2;
      int n;
      rst_n      = 1'b0;
      req_i      = '0;
      sync_ack_i = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_outputs", 32'({sync_ctrl_o, sync_id_o, done_o, err_o, pending_o, busy_o}), 32'd0);
      rst_n = 1'b1;

      // Single request from requester 2, acked 5 cycles after the issue.
      $display("[TB] single request");
      applyStimulus(4'b0100, 1'b0);
      t = cyc;
      waitCtrl(c, id);
      checkOutput("single_issue_latency", c - t, 2);
      checkOutput("single_id", id, 2);
      repeat (4) applyStimulus(4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("single_done", 32'(done_o), 32'h4);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("single_done_width", 32'(done_o), 0);
      checkOutput("single_busy_gap", 32'(busy_o), 1);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("single_busy_low", 32'(busy_o), 0);

      // Round-robin order for three simultaneous requests, then pointer wrap.
      $display("[TB] round robin");
      doReset();
      applyStimulus(4'b1011, 1'b0);
      for (int k = 0; k < 3; k++) begin
         waitCtrl(c, id);
         checkOutput("rr_order", id, rr_ids[k]);
         checkOutput("rr_pending", 32'(pending_o), 32'(rr_pend[k]));
         applyStimulus(4'b0000, 1'b0);
         applyStimulus(4'b0000, 1'b1);
         applyStimulus(4'b0000, 1'b0);
      end
      applyStimulus(4'b1001, 1'b0);
      waitCtrl(c, id);
      checkOutput("rr_ptr_wrap", id, 0);
      checkOutput("rr_wrap_pending", 32'(pending_o), 32'h8);

      // Timeout with no ack. Requester 3 queues during the wait.
      $display("[TB] timeout");
      doReset();
      applyStimulus(4'b0010, 1'b0);
      waitCtrl(c, id);
      checkOutput("timeout_id", id, 1);
      e = -1;
      for (int i = 0; i < 40; i++) begin
         applyStimulus((i == 2) ? 4'b1000 : 4'b0000, 1'b0);
         if (err_o != 4'b0000) begin
            e = cyc;
            break;
         end
      end
      checkOutput("timeout_seen", (e >= 0) ? 32'd1 : 32'd0, 32'd1);
      checkOutput("timeout_latency", e - c, 17);
      checkOutput("timeout_err", 32'(err_o), 32'h2);
      checkOutput("timeout_no_done", 32'(done_o), 0);
      waitCtrl(c2, id2);
      checkOutput("timeout_next_issue", c2 - e, 3);
      checkOutput("timeout_next_id", id2, 3);

      // Ack in the 16th (final) wait cycle of the requester 3 transaction.
      $display("[TB] ack/timeout collision");
      repeat (15) applyStimulus(4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("collision_done", 32'(done_o), 32'h8);
      checkOutput("collision_err", 32'(err_o), 0);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("collision_err_late", 32'(err_o), 0);

      // Re-request in the clearing cycle and again during the wait.
      $display("[TB] re-request merge");
      doReset();
      applyStimulus(4'b0010, 1'b0);
      t = cyc;
      applyStimulus(4'b0010, 1'b0);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("rereq_ctrl", 32'(sync_ctrl_o), 1);
      checkOutput("rereq_pending_kept", 32'(pending_o), 32'h2);
      applyStimulus(4'b0010, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("rereq_pending_wait", 32'(pending_o), 32'h2);
      waitCtrl(c, id);
      checkOutput("rereq_reissue_time", c - t, 8);
      checkOutput("rereq_reissue_id", id, 1);
      checkOutput("rereq_pending_clear", 32'(pending_o), 0);
      applyStimulus(4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      n = 0;
      repeat (15) begin
         applyStimulus(4'b0000, 1'b0);
         if (sync_ctrl_o) n++;
      end
      checkOutput("rereq_single_reissue", n, 0);

      // Asynchronous reset during WAIT, then a stray ack.
      $display("[TB] reset mid-operation");
      doReset();
      applyStimulus(4'b0111, 1'b0);
      waitCtrl(c, id);
      applyStimulus(4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("midreset_pending", 32'(pending_o), 32'h6);
      checkOutput("midreset_busy", 32'(busy_o), 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_async_zero", 32'({sync_ctrl_o, sync_id_o, done_o, err_o, pending_o, busy_o}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("stray_ack_done", 32'(done_o), 0);
      checkOutput("stray_ack_busy", 32'(busy_o), 0);
      repeat (4) applyStimulus(4'b0000, 1'b0);
      checkOutput("post_reset_pending", 32'(pending_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ctrl_sync_arb.md
# ctrl_sync_arb

Round-robin scheduler that shares one `ctrl_sync` pulse channel among `NUM_REQ` source-side requesters. It latches single-cycle request pulses and issues at most one pulse at a time into the synchronizer's `ctrl_i`, with the requester index on a held side bus. It then waits for a destination acknowledge, which is returned already synchronized into this clock by a reverse `ctrl_sync`. No request pulse is ever lost or overlapped, and a stuck channel is bounded by a timeout.

## Interface

Parameters:

- `NUM_REQ`, 4 — number of requesters, legal range 2..8.
- `ID_W`, 2 — width of `sync_id_o`; must satisfy `2**ID_W >= NUM_REQ`.
- `GAP_CYC`, 2 — idle cycles enforced after ack or timeout before the next issue; 0 is legal.
- `TIMEOUT`, 255 — number of WAIT cycles allowed for an ack; legal range 1..2**CNT_W-1.
- `CNT_W`, 8 — width of the timeout and gap counters.

Ports:

- `clk`  in  1 — single clock; source domain of the shared `ctrl_sync`.
- `rst_n`  in  1 — reset, asynchronous assert, active-low.
- `req_i`  in  NUM_REQ — per-requester single-cycle request pulses.
- `sync_ack_i`  in  1 — single-cycle ack from the destination, already synchronized to `clk`.
- `sync_ctrl_o`  out  1 — single-cycle pulse into `ctrl_sync.ctrl_i`.
- `sync_id_o`  out  ID_W — index of the granted requester; stable from ISSUE until the return to IDLE.
- `done_o`  out  NUM_REQ — one-cycle pulse on the granted bit when its ack is received.
- `err_o`  out  NUM_REQ — one-cycle pulse on the granted bit when its request times out.
- `pending_o`  out  NUM_REQ — latched requests not yet issued.
- `busy_o`  out  1 — high whenever the state is not IDLE.

## Operation

- **Pending register:** `pending[i]` is set by `req_i[i]` and cleared when requester i is issued. Set wins over clear in the same cycle. Repeated pulses while pending merge into one request.
- **Round-robin:** pointer `ptr` starts at 0. In IDLE the first set pending bit at or after `ptr` is selected, searching upward with wrap. On issue, `ptr <= sel+1`, wrapping to 0 after NUM_REQ-1.
- **FSM states:**
  - **IDLE:** if `pending != 0`, register `sel`, drive `sync_id_o <= sel` and `sync_ctrl_o <= 1`, clear `pending[sel]`, go to ISSUE.
  - **ISSUE:** one cycle with `sync_ctrl_o` high; clear the timer; go to WAIT.
  - **WAIT:** `sync_ack_i` gives `done_o[sel] <= 1` and a move to GAP. Otherwise the timer increments; if this is the TIMEOUT-th WAIT cycle without an ack, `err_o[sel] <= 1` and move to GAP. An ack in that same final cycle wins: `done_o`, no `err_o`.
  - **GAP:** stay for GAP_CYC cycles, then go to IDLE. With GAP_CYC=0, WAIT exits directly to IDLE.
- `sync_ack_i` outside WAIT is ignored.
- **Reset:** state IDLE, `ptr`=0, pending=0, counters=0. Every output is 0: `sync_ctrl_o`, `sync_id_o`, `done_o`, `err_o`, `pending_o`, `busy_o`.
- **Reset mid-operation:** discards pending and outstanding requests. No `done_o` or `err_o` is emitted for them.
- **Outputs:** all are registered except `pending_o` and `busy_o`, which are direct register/state decodes.

## Timing

- **Request to issue:** `req_i` pulse in cycle t sets `pending` at t+1. From IDLE, `sync_ctrl_o` is high in cycle t+2, with `sync_id_o` valid the same cycle.
- **Issue cycle:** `busy_o` rises in the ISSUE cycle. `pending_o[sel]` drops in the same cycle unless it was re-set.
- **Ack:** `sync_ack_i` in WAIT cycle a gives `done_o` in a+1. GAP occupies a+1..a+GAP_CYC, IDLE is reached at a+1+GAP_CYC, and the earliest next `sync_ctrl_o` is at a+2+GAP_CYC.
- **Timeout:** with ISSUE in cycle i, WAIT spans i+1..i+TIMEOUT and `err_o` is high at i+TIMEOUT+1.
- **Issue rate:** at most one `sync_ctrl_o` per (3 + GAP_CYC + ack latency) cycles. This guarantees the `ctrl_sync` clear loop settles between pulses.

## Test plan

- **Single request:** `req_i[2]` pulse; ack 5 cycles after `sync_ctrl_o` -> one-cycle `sync_ctrl_o`, `sync_id_o`=2 held, `done_o`=4'b0100 for one cycle, `busy_o` low 2 cycles after `done_o` (GAP_CYC=2).
- **Round-robin order:** `req_i`=4'b1011 in one cycle after reset, with ack in each WAIT -> issue order 0, 1, 3; `ptr` ends at 0; `pending_o` goes 1010 -> 1000 -> 0000.
- **Timeout:** TIMEOUT=16, no ack -> `err_o[sel]` high exactly 17 cycles after `sync_ctrl_o`, no `done_o`, next issue after GAP.
- **Ack/timeout collision:** ack arrives in the 16th WAIT cycle with TIMEOUT=16 -> `done_o` pulse, `err_o` stays 0.
- **Re-request at clear:** requester 1 pulses again in the same cycle its pending bit is cleared, and again during WAIT -> `pending_o[1]` stays 1; it is re-issued once after GAP (merge), with no loss.
- **Reset mid-operation:** `rst_n` low during WAIT with pending=4'b0110 -> all outputs 0 asynchronously; after release, a stray `sync_ack_i` produces no `done_o`.
